// File: rtl/alu_reg_join_if.sv
// Control-side bus of the ALU/register-bank/data-memory datapath slice.
// The control unit drives the master side and the datapath is the slave.
interface alu_reg_join_if;
  logic [15:0] Y_KMx_IN;
  logic        Y_X_Kmx_Sel;
  logic [5:0]  SEL_A_RB;
  logic [5:0]  SEL_B_RB;
  logic [5:0]  C_SEL_RB;
  logic [3:0]  ALUC_IN;
  logic        CY_IN;
  logic [1:0]  Shifter_Sel;
  logic [9:0]  DAddr;
  logic        Rd;
  logic        Wr;
  logic [15:0] W_Block1;
  logic        CY_OUT;

  modport master (
    output Y_KMx_IN, Y_X_Kmx_Sel, SEL_A_RB, SEL_B_RB, C_SEL_RB,
           ALUC_IN, CY_IN, Shifter_Sel, DAddr, Rd, Wr,
    input  W_Block1, CY_OUT
  );

  modport slave (
    input  Y_KMx_IN, Y_X_Kmx_Sel, SEL_A_RB, SEL_B_RB, C_SEL_RB,
           ALUC_IN, CY_IN, Shifter_Sel, DAddr, Rd, Wr,
    output W_Block1, CY_OUT
  );
endinterface

// File: rtl/alu_reg_join.sv
// Datapath slice: 64x16 register bank -> 16-bit ALU -> shifter / 1024x16 data
// memory -> W_Block1, which is written back to the bank every clock.
module alu_reg_join #(
  parameter int DW    = 16,
  parameter int RB_AW = 6,
  parameter int DM_AW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  alu_reg_join_if.slave bus
);
  localparam int RB_N = 1 << RB_AW;
  localparam int DM_N = 1 << DM_AW;

  logic [DW-1:0] rb_q [RB_N];
  logic [DW-1:0] rb_d [RB_N];
  logic [DW-1:0] dm_q [DM_N];

  logic [DW-1:0] a, y, r, s, w;
  logic [DW:0]   sum;
  logic          c, cy;
  logic          dm_we;

  // Entry 0 is held at zero so reads of register 0 need no special case.
  always_comb begin
    a = rb_q[bus.SEL_A_RB];
    y = bus.Y_X_Kmx_Sel ? bus.Y_KMx_IN : rb_q[bus.SEL_B_RB];
  end

  always_comb begin
    sum = '0;
    case (bus.ALUC_IN)
      4'd0:    sum = {1'b0, a} + {1'b0, y};
      4'd1:    sum = {1'b0, a} + {1'b0, y} + {{DW{1'b0}}, bus.CY_IN};
      4'd2:    sum = {1'b0, a} + {1'b0, ~y} + {{DW{1'b0}}, 1'b1};
      4'd3:    sum = {1'b0, a} + {1'b0, ~y} + {{DW{1'b0}}, bus.CY_IN};
      4'd4:    sum = {1'b0, a & y};
      4'd5:    sum = {1'b0, a | y};
      4'd6:    sum = {1'b0, a ^ y};
      4'd7:    sum = {1'b0, ~a};
      4'd8:    sum = {1'b0, a};
      4'd9:    sum = {1'b0, y};
      4'd10:   sum = {1'b0, a} + {{DW{1'b0}}, 1'b1};
      4'd11:   sum = {1'b0, a} + {1'b0, {DW{1'b1}}};
      4'd12:   sum = {1'b0, ~a} + {{DW{1'b0}}, 1'b1};
      4'd13:   sum = {1'b0, ~(a & y)};
      4'd14:   sum = {1'b0, ~(a | y)};
      default: sum = {1'b0, ~(a ^ y)};
    endcase
    r = sum[DW-1:0];
    c = sum[DW];
  end

  always_comb begin
    s  = r;
    cy = c;
    case (bus.Shifter_Sel)
      2'b01:   begin s = {r[DW-2:0], 1'b0};    cy = r[DW-1]; end
      2'b10:   begin s = {1'b0, r[DW-1:1]};    cy = r[0];    end
      2'b11:   begin s = {r[DW-1], r[DW-1:1]}; cy = r[0];    end
      default: begin s = r;                    cy = c;       end
    endcase
    w = bus.Rd ? dm_q[bus.DAddr] : s;
  end

  assign bus.W_Block1 = w;
  assign bus.CY_OUT   = cy;

  always_comb begin
    rb_d = rb_q;
    if (bus.C_SEL_RB != '0) rb_d[bus.C_SEL_RB] = w;
    rb_d[0] = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RB_N; i++) rb_q[i] <= '0;
    end else begin
      rb_q <= rb_d;
    end
  end

  // Memory is not reset; stores are merely suppressed while RST is high.
  always_comb dm_we = bus.Wr & ~RST;

  always_ff @(posedge CLK) begin
    if (dm_we) dm_q[bus.DAddr] <= a;
  end
endmodule

// File: tb/tb_alu_reg_join.sv
// Directed-vector bench for alu_reg_join with hand-computed expectations.
module tb_alu_reg_join;
  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [15:0] v;

  alu_reg_join_if bus ();

  alu_reg_join dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.Y_KMx_IN = '0; bus.Y_X_Kmx_Sel = 1'b0; bus.SEL_A_RB = '0;
    bus.SEL_B_RB = '0; bus.C_SEL_RB = '0;      bus.ALUC_IN = '0;
    bus.CY_IN = 1'b0;  bus.Shifter_Sel = '0;   bus.DAddr = '0;
    bus.Rd = 1'b0;     bus.Wr = 1'b0;
  endtask

  // Drive on the falling edge so a few #1 settle/check steps fit before the next rise.
  task automatic sync();
    @(negedge CLK);
    idle();
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    bus.C_SEL_RB = '0;
    bus.Wr = 1'b0;
  endtask

  task automatic load(input logic [5:0] r, input logic [15:0] val);
    sync();
    bus.Y_X_Kmx_Sel = 1'b1; bus.Y_KMx_IN = val; bus.ALUC_IN = 4'd9; bus.C_SEL_RB = r;
    tick();
  endtask

  task automatic rd_reg(input logic [5:0] r, output logic [15:0] val);
    sync();
    bus.SEL_A_RB = r; bus.ALUC_IN = 4'd8;
    #1;
    val = bus.W_Block1;
  endtask

  // A = RB[ra], Y = imm, returns after settle with outputs valid.
  task automatic alu_imm(input logic [5:0] ra, input logic [15:0] imm, input logic [3:0] op,
                         input logic cin, input logic [1:0] sh);
    sync();
    bus.SEL_A_RB = ra; bus.Y_X_Kmx_Sel = 1'b1; bus.Y_KMx_IN = imm;
    bus.ALUC_IN = op; bus.CY_IN = cin; bus.Shifter_Sel = sh;
    #1;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    #12;
    chk("reset_w", bus.W_Block1, 16'h0000);
    chk("reset_cy", bus.CY_OUT, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    // Immediate load into RB[3]
    sync();
    bus.Y_X_Kmx_Sel = 1'b1; bus.Y_KMx_IN = 16'h1234; bus.ALUC_IN = 4'd9; bus.C_SEL_RB = 6'd3;
    #1;
    chk("imm_pre_edge", bus.W_Block1, 16'h1234);
    tick();
    rd_reg(6'd3, v);
    chk("imm_rb3", v, 16'h1234);

    // Arithmetic and carry
    load(6'd1, 16'hFFFF);
    load(6'd5, 16'h0005);
    load(6'd6, 16'h0001);
    alu_imm(6'd1, 16'h0001, 4'd0, 1'b0, 2'b00);
    chk("add_w", bus.W_Block1, 16'h0000);
    chk("add_cy", bus.CY_OUT, 1'b1);
    alu_imm(6'd5, 16'h0007, 4'd2, 1'b0, 2'b00);
    chk("sub_w", bus.W_Block1, 16'hFFFE);
    chk("sub_cy", bus.CY_OUT, 1'b0);
    alu_imm(6'd6, 16'h0001, 4'd1, 1'b1, 2'b00);
    chk("adc_w", bus.W_Block1, 16'h0003);
    alu_imm(6'd5, 16'h0007, 4'd3, 1'b0, 2'b00);
    chk("sbc_w", bus.W_Block1, 16'hFFFD);
    alu_imm(6'd1, 16'h0F0F, 4'd6, 1'b0, 2'b00);
    chk("xor_w", bus.W_Block1, 16'hF0F0);
    alu_imm(6'd1, 16'h0F0F, 4'd13, 1'b0, 2'b00);
    chk("nand_w", bus.W_Block1, 16'hF0F0);
    alu_imm(6'd6, 16'h0000, 4'd12, 1'b0, 2'b00);
    chk("neg_w", bus.W_Block1, 16'hFFFF);
    chk("neg_cy", bus.CY_OUT, 1'b0);
    alu_imm(6'd6, 16'h0000, 4'd11, 1'b0, 2'b00);
    chk("dec_w", bus.W_Block1, 16'h0000);
    chk("dec_cy", bus.CY_OUT, 1'b1);
    alu_imm(6'd1, 16'h0000, 4'd10, 1'b0, 2'b00);
    chk("inc_w", bus.W_Block1, 16'h0000);
    chk("inc_cy", bus.CY_OUT, 1'b1);
    alu_imm(6'd1, 16'h00FF, 4'd4, 1'b0, 2'b00);
    chk("and_cy_logic", {bus.CY_OUT, bus.W_Block1}, {1'b0, 16'h00FF});

    // Shifter on R = 0x8001
    alu_imm(6'd0, 16'h8001, 4'd9, 1'b0, 2'b01);
    chk("shl_w", bus.W_Block1, 16'h0002);
    chk("shl_cy", bus.CY_OUT, 1'b1);
    alu_imm(6'd0, 16'h8001, 4'd9, 1'b0, 2'b10);
    chk("shr_w", bus.W_Block1, 16'h4000);
    chk("shr_cy", bus.CY_OUT, 1'b1);
    alu_imm(6'd0, 16'h8001, 4'd9, 1'b0, 2'b11);
    chk("asr_w", bus.W_Block1, 16'hC000);
    chk("asr_cy", bus.CY_OUT, 1'b1);

    // Register 0 ignores writes
    load(6'd0, 16'hABCD);
    rd_reg(6'd0, v);
    chk("rb0_zero", v, 16'h0000);

    // Store / load
    load(6'd2, 16'h5A5A);
    sync();
    bus.SEL_A_RB = 6'd2; bus.DAddr = 10'h3FF; bus.Wr = 1'b1;
    tick();
    sync();
    bus.DAddr = 10'h3FF; bus.Rd = 1'b1; bus.C_SEL_RB = 6'd4;
    #1;
    chk("dm_load", bus.W_Block1, 16'h5A5A);
    tick();
    rd_reg(6'd4, v);
    chk("dm_to_rb4", v, 16'h5A5A);

    // Same-address read and write: old data before the edge, new after
    sync();
    bus.SEL_A_RB = 6'd6; bus.DAddr = 10'h3FF; bus.Rd = 1'b1; bus.Wr = 1'b1;
    bus.Y_X_Kmx_Sel = 1'b1; bus.Y_KMx_IN = 16'h0001; bus.ALUC_IN = 4'd0;
    #1;
    chk("rw_old", bus.W_Block1, 16'h5A5A);
    chk("rw_cy_indep", bus.CY_OUT, 1'b0);
    tick();
    chk("rw_new", bus.W_Block1, 16'h0001);

    // Asynchronous reset between edges, writes blocked while held
    sync();
    bus.SEL_A_RB = 6'd3; bus.ALUC_IN = 4'd8;
    #1;
    chk("pre_rst_rb3", bus.W_Block1, 16'h1234);
    #1;
    RST = 1'b1;
    #1;
    chk("async_rst_rb3", bus.W_Block1, 16'h0000);
    sync();
    bus.Y_X_Kmx_Sel = 1'b1; bus.Y_KMx_IN = 16'h9999; bus.ALUC_IN = 4'd9; bus.C_SEL_RB = 6'd3;
    tick();
    rd_reg(6'd3, v);
    chk("rst_hold_rb3", v, 16'h0000);
    RST = 1'b0;
    rd_reg(6'd4, v);
    chk("rst_cleared_rb4", v, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
